scan_dump_writer: RTL and testbench

- Upstream feeder for the 256-byte SIPO capture buffer.
- On a start pulse it shifts a DUT scan chain out serially and groups the bits into 32-bit words.
- Each word goes through the buffer's write handshake: request (val_op, op=wr), wait for op_ack, stream 32 bits LSB-first on sin, wait for op_commit.
- Optional recirculation restores the chain contents, making the dump non-destructive.

---
 rtl/scan_dump_writer_pkg.sv | 20 ++
 rtl/scan_dump_writer_timer.sv | 29 ++
 rtl/scan_dump_writer.sv | 119 +++++++++++
 tb/tb_scan_dump_writer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_dump_writer_pkg.sv
// scan_pkg: shared types and constants for the scan dump writer.
//   state_t   - dump FSM states
//   OP_WR/RD  - capture-buffer operation codes
//   WORD_W    - bits per buffer word
//   BUF_WORDS - capture-buffer depth in words
package scan_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SHIFT, S_WCOMMIT, S_DONE, S_ERR
  } state_t;

  localparam logic OP_WR     = 1'b0;
  localparam logic OP_RD     = 1'b1;
  localparam int   WORD_W    = 32;
  localparam int   BUF_WORDS = 64;

  // Number of buffer words needed to hold a chain of the given length.
  function automatic int words_for(input int bits);
    return (bits + WORD_W - 1) / WORD_W;
  endfunction
endpackage

// File: rtl/scan_dump_writer_timer.sv
// hs_timeout_timer: handshake wait timer.
//   clk, reset - clock, async active-high reset
//   clr        - zero the count (wins over en)
//   en         - count one cycle of waiting
//   expired    - high during the LIMIT-th consecutive enabled cycle
module hs_timeout_timer #(
  parameter int LIMIT = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int            TW   = $clog2(LIMIT + 1);
  localparam logic [TW-1:0] LAST = TW'(LIMIT - 1);

  logic [TW-1:0] cnt;

  // cnt holds the number of waiting cycles already elapsed, so the cycle
  // in which it equals LIMIT-1 is the last one allowed.
  assign expired = en && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (en && !expired)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/scan_dump_writer.sv
// scan_dump_writer: shifts a DUT scan chain out and writes it, 32 bits per
// word, into the SIPO capture buffer through its request/ack/commit handshake.
//   clk, reset         - clock, async active-high reset
//   start              - pulse; begins a dump when idle
//   chain_so/chain_si  - DUT chain scan-out / scan-in
//   scan_en            - DUT chain shift enable
//   sin                - serial word data to buffer, LSB first
//   val_op, op         - buffer request valid / op type (always write)
//   op_ack, op_commit  - buffer accepted request / stored word
//   busy, done, err    - status: dump in progress / finished pulse / sticky timeout
//   word_cnt           - words committed in the current or last dump
module scan_dump_writer
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 100,  // 1..2048
  parameter int RECIRC    = 1,
  parameter int TIMEOUT   = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       chain_so,
  output logic       chain_si,
  output logic       scan_en,
  output logic       sin,
  output logic       val_op,
  output logic       op,
  input  logic       op_ack,
  input  logic       op_commit,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [6:0] word_cnt
);
  localparam int            NWORDS      = words_for(CHAIN_LEN);
  localparam int            CW          = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] CHAIN_LEN_C = CW'(CHAIN_LEN);
  localparam logic [6:0]    NWORDS_C    = 7'(NWORDS);

  state_t        state;
  logic [4:0]    bit_cnt;
  logic [CW-1:0] chain_cnt;
  logic          chain_live, waiting, tmr_clr, tmr_exp;

  // Once the chain is exhausted the rest of the last word is zero padding
  // and the chain is held still.
  assign chain_live = (chain_cnt < CHAIN_LEN_C);

  // Moore decodes of registered state; sin passes chain_so through in the
  // same cycle the chain is shifted.
  assign scan_en  = (state == S_SHIFT) && chain_live;
  assign sin      = scan_en & chain_so;
  assign chain_si = (RECIRC != 0) ? (scan_en & chain_so) : 1'b0;
  assign val_op   = (state == S_REQ);
  assign op       = OP_WR;
  assign busy     = (state == S_REQ) || (state == S_SHIFT) || (state == S_WCOMMIT);
  assign done     = (state == S_DONE);

  // One timer serves both waits; it is zeroed whenever the wait is
  // satisfied so a WCOMMIT->REQ hop starts the next wait from zero.
  assign waiting = (state == S_REQ) || (state == S_WCOMMIT);
  assign tmr_clr = !waiting
                || ((state == S_REQ)     && op_ack)
                || ((state == S_WCOMMIT) && op_commit);

  hs_timeout_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (waiting),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      chain_cnt <= '0;
      word_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state     <= S_REQ;
          bit_cnt   <= '0;
          chain_cnt <= '0;
          word_cnt  <= '0;
          err       <= 1'b0;
        end
        S_REQ: begin
          if (op_ack) begin
            state   <= S_SHIFT;
            bit_cnt <= '0;
          end else if (tmr_exp) begin
            state <= S_ERR;
            err   <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (chain_live) chain_cnt <= chain_cnt + 1'b1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 5'd31) state <= S_WCOMMIT;
        end
        S_WCOMMIT: begin
          if (op_commit) begin
            word_cnt <= word_cnt + 7'd1;
            state    <= (word_cnt + 7'd1 == NWORDS_C) ? S_DONE : S_REQ;
          end else if (tmr_exp) begin
            state <= S_ERR;
            err   <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scan_dump_writer.sv
// Bench for scan_dump_writer: a 64-bit chain instance (index 0) and a 40-bit
// chain instance (index 1), each with a shift-register chain model and a
// capture-buffer model that acks 2 cycles into a request and commits in the
// cycle after bit 31.
module tb_scan_dump_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start [2] = '{1'b0, 1'b0};
  logic       chain_so [2], chain_si [2], scan_en [2], sin [2], val_op [2], op [2];
  logic       busy [2], done [2], err [2];
  logic [6:0] word_cnt [2];
  logic       op_ack [2] = '{1'b0, 1'b0};
  logic       op_commit [2] = '{1'b0, 1'b0};

  scan_dump_writer #(.CHAIN_LEN(64), .RECIRC(1), .TIMEOUT(200)) u_dut64 (
    .clk(clk), .reset(reset), .start(start[0]), .chain_so(chain_so[0]), .chain_si(chain_si[0]),
    .scan_en(scan_en[0]), .sin(sin[0]), .val_op(val_op[0]), .op(op[0]), .op_ack(op_ack[0]),
    .op_commit(op_commit[0]), .busy(busy[0]), .done(done[0]), .err(err[0]), .word_cnt(word_cnt[0]));

  scan_dump_writer #(.CHAIN_LEN(40), .RECIRC(1), .TIMEOUT(200)) u_dut40 (
    .clk(clk), .reset(reset), .start(start[1]), .chain_so(chain_so[1]), .chain_si(chain_si[1]),
    .scan_en(scan_en[1]), .sin(sin[1]), .val_op(val_op[1]), .op(op[1]), .op_ack(op_ack[1]),
    .op_commit(op_commit[1]), .busy(busy[1]), .done(done[1]), .err(err[1]), .word_cnt(word_cnt[1]));

  // ---------------- chain model ----------------
  logic [63:0] chain [2];
  logic [63:0] ld_val [2];
  logic        ld [2] = '{1'b0, 1'b0};

  function automatic int clen(input int g);
    return (g == 0) ? 64 : 40;
  endfunction

  always_comb for (int g = 0; g < 2; g++) chain_so[g] = chain[g][0];

  always @(posedge clk)
    for (int g = 0; g < 2; g++)
      if (ld[g]) chain[g] <= ld_val[g];
      else if (scan_en[g]) chain[g] <= (chain[g] >> 1) | (64'(chain_si[g]) << (clen(g) - 1));

  // ---------------- buffer model ----------------
  bit          nack [2] = '{1'b0, 1'b0};
  bit          spur [2] = '{1'b0, 1'b0};
  int          mode [2] = '{0, 0};
  int          wcnt [2] = '{0, 0};
  int          bi [2] = '{0, 0};
  logic [31:0] cur [2];
  logic [31:0] wbuf [2][8];
  int          wn [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          se_cnt [2] = '{0, 0};
  int          vs_bad [2] = '{0, 0};

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        mode[g] = 0; wcnt[g] = 0; bi[g] = 0; op_ack[g] = 1'b0; op_commit[g] = 1'b0;
      end else begin
        if (done[g]) done_cnt[g]++;
        if (scan_en[g]) se_cnt[g]++;
        case (mode[g])
          0: begin
            op_commit[g] = 1'b0;
            if (val_op[g]) begin
              if (spur[g] && wcnt[g] == 0) op_commit[g] = 1'b1;
              wcnt[g]++;
              if (wcnt[g] == 2 && !nack[g]) begin op_ack[g] = 1'b1; mode[g] = 1; bi[g] = 0; end
            end else wcnt[g] = 0;
          end
          1: begin
            op_ack[g] = 1'b0;
            if (val_op[g]) vs_bad[g]++;
            cur[g][bi[g]] = sin[g];
            if (bi[g] == 31) mode[g] = 2; else bi[g]++;
          end
          default: begin
            op_commit[g] = 1'b1;
            wbuf[g][wn[g] % 8] = cur[g];
            wn[g]++;
            mode[g] = 0; wcnt[g] = 0;
          end
        endcase
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  int pass_cnt = 0;
  int tot_cnt = 0;

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic load_chain(input int g, input logic [63:0] v);
    ld_val[g] = v; ld[g] = 1'b1; tick(); ld[g] = 1'b0;
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1; tick(); start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, output bit ok);
    int d0 = done_cnt[g];
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      if (done_cnt[g] != d0) ok = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      tot_cnt++;
      if ({scan_en[g], sin[g], val_op[g], op[g], busy[g], done[g], err[g], word_cnt[g]} !== 14'd0)
        $display("FAIL reset_outputs[%0d]: got %b want all 0", g,
                 {scan_en[g], sin[g], val_op[g], op[g], busy[g], done[g], err[g], word_cnt[g]});
      else pass_cnt++;
    end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_dump64();
    bit ok;
    int w0 = wn[0], d0 = done_cnt[0], v0 = vs_bad[0];
    load_chain(0, 64'hdeadbeef_07020106);
    pulse_start(0);
    wait_done(0, ok);
    repeat (4) tick();
    tot_cnt++; if (ok !== 1'b1) $display("FAIL dump64_done: got no done, want done"); else pass_cnt++;
    tot_cnt++; if (wbuf[0][w0 % 8] !== 32'h07020106) $display("FAIL dump64_word0: got %h want 07020106", wbuf[0][w0 % 8]); else pass_cnt++;
    tot_cnt++; if (wbuf[0][(w0 + 1) % 8] !== 32'hdeadbeef) $display("FAIL dump64_word1: got %h want deadbeef", wbuf[0][(w0 + 1) % 8]); else pass_cnt++;
    tot_cnt++; if (wn[0] - w0 != 2) $display("FAIL dump64_nwords: got %0d want 2", wn[0] - w0); else pass_cnt++;
    tot_cnt++; if (word_cnt[0] !== 7'd2) $display("FAIL dump64_word_cnt: got %0d want 2", word_cnt[0]); else pass_cnt++;
    tot_cnt++; if (done_cnt[0] - d0 != 1) $display("FAIL dump64_done_pulses: got %0d want 1", done_cnt[0] - d0); else pass_cnt++;
    tot_cnt++; if ({err[0], busy[0]} !== 2'b00) $display("FAIL dump64_err_busy: got %b want 00", {err[0], busy[0]}); else pass_cnt++;
    tot_cnt++; if (vs_bad[0] != v0) $display("FAIL dump64_val_op_in_shift: got %0d want 0", vs_bad[0] - v0); else pass_cnt++;
    tot_cnt++; if (chain[0] !== 64'hdeadbeef_07020106) $display("FAIL dump64_chain_restored: got %h want deadbeef07020106", chain[0]); else pass_cnt++;
  endtask

  task automatic test_pad40();
    bit ok;
    int w0 = wn[1], s0 = se_cnt[1];
    load_chain(1, 64'h000000a5_12345678);
    pulse_start(1);
    wait_done(1, ok);
    repeat (2) tick();
    tot_cnt++; if (ok !== 1'b1) $display("FAIL pad40_done: got no done, want done"); else pass_cnt++;
    tot_cnt++; if (wbuf[1][w0 % 8] !== 32'h12345678) $display("FAIL pad40_word0: got %h want 12345678", wbuf[1][w0 % 8]); else pass_cnt++;
    tot_cnt++; if (wbuf[1][(w0 + 1) % 8] !== 32'h000000a5) $display("FAIL pad40_word1: got %h want 000000a5", wbuf[1][(w0 + 1) % 8]); else pass_cnt++;
    tot_cnt++; if (se_cnt[1] - s0 != 40) $display("FAIL pad40_scan_en_cycles: got %0d want 40", se_cnt[1] - s0); else pass_cnt++;
    tot_cnt++; if (word_cnt[1] !== 7'd2) $display("FAIL pad40_word_cnt: got %0d want 2", word_cnt[1]); else pass_cnt++;
    tot_cnt++; if (chain[1] !== 64'h000000a5_12345678) $display("FAIL pad40_chain_restored: got %h want a512345678", chain[1]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    logic [31:0] exp [4] = '{32'h89abcdef, 32'h01234567, 32'h89abcdef, 32'h01234567};
    int w0 = wn[0];
    load_chain(0, 64'h01234567_89abcdef);
    pulse_start(0);
    wait_done(0, ok1);
    pulse_start(0);
    wait_done(0, ok2);
    repeat (2) tick();
    tot_cnt++; if ({ok1, ok2} !== 2'b11) $display("FAIL b2b_done: got %b want 11", {ok1, ok2}); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tot_cnt++;
      if (wbuf[0][(w0 + i) % 8] !== exp[i]) $display("FAIL b2b_word%0d: got %h want %h", i, wbuf[0][(w0 + i) % 8], exp[i]);
      else pass_cnt++;
    end
    tot_cnt++; if (chain[0] !== 64'h01234567_89abcdef) $display("FAIL b2b_chain_restored: got %h want 0123456789abcdef", chain[0]); else pass_cnt++;
  endtask

  task automatic test_timeout();
    bit ok;
    int w0 = wn[0], d0 = done_cnt[0];
    nack[0] = 1'b1;
    load_chain(0, 64'hdeadbeef_07020106);
    pulse_start(0);  // now in REQ cycle 1
    repeat (199) tick();  // REQ cycle 200
    tot_cnt++; if ({err[0], val_op[0]} !== 2'b01) $display("FAIL timeout_before: got err,val_op=%b want 01", {err[0], val_op[0]}); else pass_cnt++;
    tick();
    tot_cnt++; if ({err[0], busy[0], val_op[0]} !== 3'b100) $display("FAIL timeout_err: got err,busy,val_op=%b want 100", {err[0], busy[0], val_op[0]}); else pass_cnt++;
    repeat (10) tick();
    tot_cnt++; if (err[0] !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", err[0]); else pass_cnt++;
    tot_cnt++; if (done_cnt[0] != d0 || wn[0] != w0) $display("FAIL timeout_no_traffic: got done %0d words %0d want 0 0", done_cnt[0] - d0, wn[0] - w0); else pass_cnt++;
    nack[0] = 1'b0;
    pulse_start(0);
    tot_cnt++; if (err[0] !== 1'b0) $display("FAIL timeout_err_cleared: got %b want 0", err[0]); else pass_cnt++;
    wait_done(0, ok);
    tot_cnt++; if (ok !== 1'b1 || wbuf[0][(w0 + 1) % 8] !== 32'hdeadbeef) $display("FAIL timeout_recover: got done=%b word1=%h want 1 deadbeef", ok, wbuf[0][(w0 + 1) % 8]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0, ok;
    int w0;
    load_chain(0, 64'hdeadbeef_07020106);
    pulse_start(0);
    for (int i = 0; i < 100 && !seen; i++) begin tick(); if (scan_en[0]) seen = 1'b1; end
    tot_cnt++; if (seen !== 1'b1) $display("FAIL rstmid_shift_seen: got no scan_en want scan_en"); else pass_cnt++;
    repeat (10) tick();  // bit_cnt = 10
    w0 = wn[0];
    reset = 1'b1;
    #1;
    tot_cnt++;
    if ({scan_en[0], sin[0], val_op[0], op[0], busy[0], done[0], err[0], word_cnt[0], chain_si[0]} !== 15'd0)
      $display("FAIL rstmid_async: got %b want all 0",
               {scan_en[0], sin[0], val_op[0], op[0], busy[0], done[0], err[0], word_cnt[0], chain_si[0]});
    else pass_cnt++;
    tick();
    reset = 1'b0;
    repeat (20) tick();
    tot_cnt++; if ({val_op[0], busy[0]} !== 2'b00 || wn[0] != w0) $display("FAIL rstmid_idle: got val_op,busy=%b words=%0d want 00 0", {val_op[0], busy[0]}, wn[0] - w0); else pass_cnt++;
    load_chain(0, 64'hdeadbeef_07020106);
    pulse_start(0);
    wait_done(0, ok);
    tot_cnt++;
    if (ok !== 1'b1 || wbuf[0][w0 % 8] !== 32'h07020106 || wbuf[0][(w0 + 1) % 8] !== 32'hdeadbeef)
      $display("FAIL rstmid_redump: got done=%b words %h %h want 1 07020106 deadbeef", ok, wbuf[0][w0 % 8], wbuf[0][(w0 + 1) % 8]);
    else pass_cnt++;
  endtask

  task automatic test_ignore();
    bit ok;
    int w0 = wn[0], d0 = done_cnt[0];
    load_chain(0, 64'hdeadbeef_07020106);
    spur[0] = 1'b1;
    pulse_start(0);
    repeat (40) tick();
    tot_cnt++; if (busy[0] !== 1'b1) $display("FAIL ignore_busy: got %b want 1", busy[0]); else pass_cnt++;
    pulse_start(0);
    wait_done(0, ok);
    repeat (4) tick();
    spur[0] = 1'b0;
    tot_cnt++; if (wbuf[0][w0 % 8] !== 32'h07020106) $display("FAIL ignore_word0: got %h want 07020106", wbuf[0][w0 % 8]); else pass_cnt++;
    tot_cnt++; if (wbuf[0][(w0 + 1) % 8] !== 32'hdeadbeef) $display("FAIL ignore_word1: got %h want deadbeef", wbuf[0][(w0 + 1) % 8]); else pass_cnt++;
    tot_cnt++; if (word_cnt[0] !== 7'd2) $display("FAIL ignore_word_cnt: got %0d want 2", word_cnt[0]); else pass_cnt++;
    tot_cnt++; if (ok !== 1'b1 || done_cnt[0] - d0 != 1 || wn[0] - w0 != 2) $display("FAIL ignore_counts: got done=%0d words=%0d want 1 2", done_cnt[0] - d0, wn[0] - w0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_dump64();
    test_pad40();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_ignore();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end
endmodule
